// File: rtl/tt_um_nasser_hadi_latch_sched_pkg.sv
// Shared types and constants for the latch-write scheduler.
// Requester count, width-code field and FSM state encoding.
package tt_um_nasser_hadi_latch_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int W_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD
  } state_t;

  function automatic logic [PTR_W-1:0] oh2idx(
    input logic [NUM_REQ-1:0] oh
  );
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tt_um_nasser_hadi_latch_sched_if.sv
// Pin bundle between the scheduler and its environment.
// master drives the inputs, slave is the scheduler itself.
interface tt_um_nasser_hadi_latch_sched_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/tt_um_nasser_hadi_latch_sched_rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping.
// N must be a power of two so the index wraps naturally.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_nasser_hadi_latch_sched.sv
// Shares one D latch among requesters: SETUP, OPEN for W+1
// cycles, HOLD; every output comes straight from a register.
module tt_um_nasser_hadi_latch_sched #(
  parameter int NUM_REQ = tt_um_nasser_hadi_latch_sched_pkg::NUM_REQ
) (
  input logic clk,
  input logic rst_n,
  tt_um_nasser_hadi_latch_sched_if.slave bus
);

  import tt_um_nasser_hadi_latch_sched_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] shadow_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      idx_q;
  logic [PW-1:0]      win_idx;
  logic [W_W-1:0]     cnt_q;
  logic               d_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic               arb_valid;
  logic               start;
  logic               win_data;
  logic               unused_ok;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.ui_in[NUM_REQ-1:0]),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign start     = bus.ena & arb_valid;
  assign win_idx   = oh2idx(arb_gnt);
  assign win_data  = |(arb_gnt & bus.ui_in[4 +: NUM_REQ]);
  assign unused_ok = &{1'b0, bus.uio_in[7:2]};

  assign bus.uo_out  = {done_q, busy_q, grant_q, en_q, d_q};
  assign bus.uio_out = {{(8-NUM_REQ){1'b0}}, shadow_q};
  assign bus.uio_oe  = 8'h0F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      shadow_q <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      d_q      <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (state_q == HOLD) shadow_q[idx_q] <= d_q;
          done_q <= 1'b0;
          if (start) begin
            state_q <= SETUP;
            grant_q <= arb_gnt;
            d_q     <= win_data;
            cnt_q   <= bus.uio_in[W_W-1:0];
            idx_q   <= win_idx;
            ptr_q   <= win_idx + PW'(1);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SETUP: begin
          state_q <= OPEN;
          en_q    <= 1'b1;
        end
        OPEN: begin
          // cnt_q was loaded with W, so OPEN lasts W+1 cycles
          if (cnt_q == '0) begin
            state_q <= HOLD;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - W_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_nasser_hadi_latch_sched.sv
// Directed bench for the latch scheduler: vector table plus
// hand sequences for back-to-back grants and mid-OPEN reset.
module tb_tt_um_nasser_hadi_latch_sched;

  typedef struct {
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t tbl[22];

  tt_um_nasser_hadi_latch_sched_if bus();

  tt_um_nasser_hadi_latch_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_sh;
    logic [7:0] exp;
    int         g;
    int         pg;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // single write, W=0
    tbl[0]  = '{1'b1, 8'h11, 8'h00, 8'h45, 8'h00};
    tbl[1]  = '{1'b1, 8'h00, 8'h00, 8'h47, 8'h00};
    tbl[2]  = '{1'b1, 8'h00, 8'h00, 8'hC5, 8'h00};
    tbl[3]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h01};
    // W=3 on requester 2
    tbl[4]  = '{1'b1, 8'h04, 8'h03, 8'h50, 8'h01};
    tbl[5]  = '{1'b1, 8'h00, 8'h03, 8'h52, 8'h01};
    tbl[6]  = '{1'b1, 8'h00, 8'h03, 8'h52, 8'h01};
    tbl[7]  = '{1'b1, 8'h00, 8'h03, 8'h52, 8'h01};
    tbl[8]  = '{1'b1, 8'h00, 8'h03, 8'h52, 8'h01};
    tbl[9]  = '{1'b1, 8'h00, 8'h03, 8'hD0, 8'h01};
    tbl[10] = '{1'b1, 8'h00, 8'h03, 8'h00, 8'h01};
    // requester 3, W=1, data and W flipped during OPEN
    tbl[11] = '{1'b1, 8'h88, 8'h01, 8'h61, 8'h01};
    tbl[12] = '{1'b1, 8'h70, 8'h03, 8'h63, 8'h01};
    tbl[13] = '{1'b1, 8'h70, 8'h03, 8'h63, 8'h01};
    tbl[14] = '{1'b1, 8'h70, 8'h03, 8'hE1, 8'h01};
    tbl[15] = '{1'b1, 8'h70, 8'h03, 8'h00, 8'h09};
    // ena gating on requester 1
    tbl[16] = '{1'b0, 8'h02, 8'h00, 8'h00, 8'h09};
    tbl[17] = '{1'b0, 8'h02, 8'h00, 8'h00, 8'h09};
    tbl[18] = '{1'b1, 8'h02, 8'h00, 8'h48, 8'h09};
    tbl[19] = '{1'b0, 8'h02, 8'h00, 8'h4A, 8'h09};
    tbl[20] = '{1'b0, 8'h02, 8'h00, 8'hC8, 8'h09};
    tbl[21] = '{1'b0, 8'h02, 8'h00, 8'h00, 8'h09};

    @(negedge clk);
    @(negedge clk);
    check("rst_uo", bus.uo_out, 8'h00);
    check("rst_uio", bus.uio_out, 8'h00);
    check("rst_oe", bus.uio_oe, 8'h0F);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      bus.ena    = tbl[i].ena;
      bus.ui_in  = tbl[i].ui;
      bus.uio_in = tbl[i].uio;
      @(negedge clk);
      check($sformatf("vec%0d_uo", i), bus.uo_out, tbl[i].exp_uo);
      check($sformatf("vec%0d_uio", i), bus.uio_out, tbl[i].exp_uio);
      check($sformatf("vec%0d_oe", i), bus.uio_oe, 8'h0F);
    end

    // reset while OPEN on requester 2 writing a 1
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h44;
    bus.uio_in = 8'h03;
    @(negedge clk);
    check("rsto_setup", bus.uo_out, 8'h51);
    bus.ui_in = 8'h00;
    @(negedge clk);
    check("rsto_open", bus.uo_out, 8'h53);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rsto_async_uo", bus.uo_out, 8'h00);
    check("rsto_async_uio", bus.uio_out, 8'h00);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rsto_after_uo", bus.uo_out, 8'h00);
    check("rsto_after_uio", bus.uio_out, 8'h00);

    // all four held: grants 0,1,2,3,0 back to back
    pat        = 4'b1010;
    exp_sh     = 4'b0000;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'hAF;
    bus.uio_in = 8'h00;
    for (int t = 0; t < 5; t++) begin
      g = t % 4;
      if (t > 0) begin
        pg = (t - 1) % 4;
        exp_sh[pg] = pat[pg];
      end
      for (int ph = 0; ph < 3; ph++) begin
        @(negedge clk);
        exp = 8'h40 | (8'h04 << g) | {7'd0, pat[g]};
        if (ph == 1) exp = exp | 8'h02;
        if (ph == 2) exp = exp | 8'h80;
        check($sformatf("rr_t%0d_p%0d_uo", t, ph), bus.uo_out, exp);
        check($sformatf("rr_t%0d_p%0d_uio", t, ph), bus.uio_out,
              {4'h0, exp_sh});
        if (t == 4 && ph == 0) bus.ui_in = 8'h00;
      end
    end
    @(negedge clk);
    check("rr_end_uo", bus.uo_out, 8'h00);
    check("rr_end_uio", bus.uio_out, 8'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_nasser_hadi_latch_sched.md
TT_UM_NASSER_HADI_LATCH_SCHED -- requirements
Module: tt_um_nasser_hadi_latch_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the one D latch.
REQ-002 clk  input  1  system clock; all state SHALL change only on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 ena  input  1  design enable; low SHALL block new grants.
REQ-005 ui_in  input  8  [3:0] req per requester (level); [7:4] data bit per requester.
REQ-006 uio_in  input  8  [1:0] open width code W (EN-high cycles = W+1); [7:2] ignored.
REQ-007 uo_out  output  8  [0] latch D; [1] latch EN; [5:2] grant one-hot; [6] busy; [7] done pulse.
REQ-008 uio_out  output  8  [3:0] shadow value last written per requester; [7:4] = 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'h0F.

Function
REQ-010 FSM states SHALL be IDLE, SETUP, OPEN, HOLD.
REQ-011 IDLE: if ena=1 and any req set, SHALL register the round-robin winner's grant, data bit and W, then go to SETUP.
REQ-012 Round-robin SHALL start searching at the requester after the last winner; after reset the search SHALL start at requester 0.
REQ-013 SETUP: one cycle; D = captured data bit, EN = 0, grant and busy asserted.
REQ-014 OPEN: EN = 1 for exactly W+1 cycles, counted by a 2-bit down-counter; D held.
REQ-015 HOLD: one cycle; EN = 0, D held, done = 1, shadow[winner] <= captured data bit.
REQ-016 From HOLD: if ena=1 and any req set, SHALL arbitrate as in IDLE and go straight to SETUP; else go to IDLE.
REQ-017 Latency: req first sampled high in IDLE at edge t -> SETUP in cycle t+1, EN high from t+2, done in cycle t+3+W.
REQ-018 Captured data and W SHALL be frozen for the whole transaction; changes on ui_in/uio_in mid-transaction SHALL have no effect.
REQ-019 Dropping req, or ena going low, mid-transaction SHALL NOT abort it; the transaction completes.
REQ-020 In IDLE: EN = 0, D = 0, grant = 0, busy = 0, done = 0.
REQ-021 EN SHALL never be high while D changes: D changes only in cycles where EN = 0.
REQ-022 At most one grant bit SHALL be high at any time.
REQ-023 Simultaneous requests SHALL be served one per transaction; no requester is starved while it holds req.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, EN = 0, D = 0, grant = 0, busy = 0, done = 0, shadow = 0, RR pointer = requester 0, counter = 0.
REQ-025 Reset mid-OPEN SHALL drop EN asynchronously; the interrupted write SHALL NOT update shadow.
REQ-026 The first grant SHALL be arbitrated on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, NUM_REQ and the width of the W field.
REQ-028 Round-robin selection SHALL live in one sub-module rr_arbiter (req, pointer -> one-hot grant, valid).
REQ-029 Outputs SHALL be driven from registers or from the state decode only, with no combinational path from ui_in to EN.

Verification
REQ-030 Single request: W=0, req0=1, data0=1 -> SETUP 1 cycle, EN high 1 cycle, done, shadow[0]=1, uio_out=8'h01.
REQ-031 Width sweep: W=3, req2, data 0 -> EN high exactly 4 cycles, grant=4'b0100 throughout, shadow[2]=0.
REQ-032 All four req held, data 4'b1010 -> grants in order 0,1,2,3,0; no IDLE between transactions; shadow=4'b1010.
REQ-033 Mid-transaction change: flip data and W during OPEN -> EN width and D unchanged, shadow gets the original bit.
REQ-034 Reset in OPEN: rst_n low for 3 ns -> EN=0 immediately, all outputs 0, shadow unchanged at 0; next grant goes to requester 0.
REQ-035 ena=0 with req1 high -> no grant; raising ena -> SETUP on the next edge.
